// File: rtl/myo_pwm_driver.sv
// Sign/magnitude PWM driver for one H-bridge: samples the signed command at period
// boundaries, blanks one dead-time-guarded period on direction reversal, latches faults.
module myo_pwm_driver #(
  parameter int PWM_PERIOD = 2000,
  parameter int DEAD_TIME  = 50
) (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [15:0] pwmRef,
  input  logic               enable,
  input  logic               fault,
  input  logic               clear_fault,
  output logic               pwm,
  output logic               dir,
  output logic               period_tick,
  output logic               fault_latched,
  output logic        [15:0] duty_applied
);

  // state     | meaning
  // S_IDLE    | output off, waits for enable at a period boundary
  // S_RUN     | pwm high for duty_applied cycles from each period start
  // S_REVERSE | one blank period; dir flips when cnt reaches DEAD_TIME
  // S_FAULT   | output off until the fault drops and clear_fault is pulsed
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REVERSE, S_FAULT} state_t;

  localparam logic [15:0] PERIOD_LEN  = 16'(PWM_PERIOD);
  localparam logic [15:0] PERIOD_LAST = 16'(PWM_PERIOD - 1);
  localparam logic [15:0] DEAD_CNT    = 16'(DEAD_TIME);

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic        started;
  logic        boundary;
  logic [16:0] ref_ext, ref_abs;
  logic [15:0] mag;
  logic        dir_req;
  state_t      cmd_state;
  logic [15:0] cmd_duty;
  logic        pwm_next, dir_next, fl_next;
  logic [15:0] duty_next;

  // The counter holds at 0 for the first edge after reset so that the first
  // cycle after release is already a period start.
  assign boundary    = started && (cnt == PERIOD_LAST);
  assign period_tick = started && (cnt == 16'd0);

  always_comb begin
    cnt_next = 16'd0;
    if (started && !boundary) cnt_next = cnt + 16'd1;
  end

  // -32768 becomes 32768 in 17 bits, then saturates like any other overrange value.
  always_comb begin
    ref_ext = {pwmRef[15], pwmRef};
    ref_abs = pwmRef[15] ? (~ref_ext + 17'd1) : ref_ext;
    mag     = (ref_abs > {1'b0, PERIOD_LEN}) ? PERIOD_LEN : ref_abs[15:0];
    dir_req = (pwmRef == 16'sd0) ? dir : pwmRef[15];
    if (dir_req != dir) begin
      cmd_state = S_REVERSE;
      cmd_duty  = 16'd0;
    end else begin
      cmd_state = S_RUN;
      cmd_duty  = mag;
    end
  end

  always_comb begin
    state_next = state;
    duty_next  = duty_applied;
    dir_next   = dir;
    fl_next    = fault_latched;
    if (fault) begin
      state_next = S_FAULT;
      fl_next    = 1'b1;
      duty_next  = 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          duty_next = 16'd0;
          if (enable && boundary) begin
            state_next = cmd_state;
            duty_next  = cmd_duty;
          end
        end
        S_RUN, S_REVERSE: begin
          if (!enable) begin
            state_next = S_IDLE;
            duty_next  = 16'd0;
          end else if (boundary) begin
            state_next = cmd_state;
            duty_next  = cmd_duty;
          end else if (state == S_REVERSE && cnt_next == DEAD_CNT) begin
            dir_next = ~dir;
          end
        end
        S_FAULT: begin
          duty_next = 16'd0;
          if (clear_fault) begin
            state_next = S_IDLE;
            fl_next    = 1'b0;
          end
        end
        default: begin
          state_next = S_IDLE;
          duty_next  = 16'd0;
        end
      endcase
    end
    // Computed from next-cycle values so a full-period duty never dips at the wrap.
    pwm_next = (state_next == S_RUN) && (cnt_next < duty_next);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= 16'd0;
      started       <= 1'b0;
      pwm           <= 1'b0;
      dir           <= 1'b0;
      fault_latched <= 1'b0;
      duty_applied  <= 16'd0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      started       <= 1'b1;
      pwm           <= pwm_next;
      dir           <= dir_next;
      fault_latched <= fl_next;
      duty_applied  <= duty_next;
    end
  end

endmodule
